// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALUCtrl codes, the
// legal-code check and the controller FSM state encoding.
// Imported by alu_share_ctrl and by anything that drives or checks it.
package alu_share_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_LSR = 4'b0011;
  localparam logic [3:0] ALU_LSL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // 1 when the code is one the ALU implements; anything else is answered
  // locally with an error response and never reaches the ALU.
  function automatic logic alu_ctrl_legal(input logic [3:0] code);
    logic ok;
    ok = 1'b0;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_LSR,
      ALU_LSL, ALU_SUB, ALU_SLT: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant_i (wrapping).
// Purely combinational, zero latency; grant is all-zero when enable_i is low.
// Ports: req_i (request vector), last_grant_i (index of previous winner),
//        enable_i, grant_o (one-hot), grant_idx_o (binary index of grant_o).
module alu_share_ctrl_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  input  logic             enable_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan from the slot after the previous winner so the last winner has the
  // lowest priority this round.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((int'(last_grant_i) + off) % N_REQ);
      if (enable_i && !found && req_i[cand]) begin
        found       = 1'b1;
        grant_o     = '0;
        grant_o[cand] = 1'b1;
        grant_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one DATA_W-bit ALU between N_REQ requesters with round-robin grant.
// Latency: accept edge T -> resp_valid visible after edge T+ALU_LAT (sampled high at T+ALU_LAT+1);
//   undefined ALUCtrl code answered right after the accept edge with err=1.
// Backpressure: response held stable until resp_ready of the granted index; no new grant meanwhile.
// Ports: CLK/Reset_L; req_valid/req_ready/req_a/req_b/req_ctrl (requester side, index-packed);
//   resp_valid/resp_ready/resp_data/resp_zero/resp_err (response side, one-hot valid, shared data);
//   alu_busa/alu_busb/alu_ctrl out to the ALU, alu_busw/alu_zero back from it.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 64,
  parameter int ALU_LAT = 2
) (
  input  logic                      CLK,
  input  logic                      Reset_L,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  input  logic [N_REQ*4-1:0]        req_ctrl,
  output logic [N_REQ-1:0]          resp_valid,
  input  logic [N_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_zero,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         alu_busa,
  output logic [DATA_W-1:0]         alu_busb,
  output logic [3:0]                alu_ctrl,
  input  logic [DATA_W-1:0]         alu_busw,
  input  logic                      alu_zero
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

  state_e              state_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   alu_busa_q;
  logic [DATA_W-1:0]   alu_busb_q;
  logic [3:0]          alu_ctrl_q;
  logic [N_REQ-1:0]    resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_zero_q;
  logic                resp_err_q;

  logic                arb_en;
  logic [N_REQ-1:0]    grant;
  logic [IDX_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [3:0]          sel_ctrl;

  // Reset_L gates the arbiter so req_ready reads 0 while reset is asserted.
  assign arb_en = (state_q == ST_IDLE) && Reset_L;

  alu_share_ctrl_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .enable_i     (arb_en),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  assign sel_a    = req_a[grant_idx*DATA_W +: DATA_W];
  assign sel_b    = req_b[grant_idx*DATA_W +: DATA_W];
  assign sel_ctrl = req_ctrl[grant_idx*4 +: 4];

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;
  assign alu_busa   = alu_busa_q;
  assign alu_busb   = alu_busb_q;
  assign alu_ctrl   = alu_ctrl_q;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q      <= ST_IDLE;
      gidx_q       <= '0;
      last_grant_q <= LAST_RST;
      cnt_q        <= '0;
      alu_busa_q   <= '0;
      alu_busb_q   <= '0;
      alu_ctrl_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            gidx_q <= grant_idx;
            if (alu_ctrl_legal(sel_ctrl)) begin
              // ALU ports only move here, so they stay quiet between jobs.
              alu_busa_q <= sel_a;
              alu_busb_q <= sel_b;
              alu_ctrl_q <= sel_ctrl;
              cnt_q      <= CNT_INIT;
              state_q    <= ST_EXEC;
            end else begin
              resp_data_q  <= '0;
              resp_zero_q  <= 1'b0;
              resp_err_q   <= 1'b1;
              resp_valid_q <= grant;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          // ALU inputs have been stable for ALU_LAT cycles when cnt_q hits 0.
          if (cnt_q == '0) begin
            resp_data_q  <= alu_busw;
            resp_zero_q  <= alu_zero;
            resp_err_q   <= 1'b0;
            resp_valid_q <= ONE << gidx_q;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready[gidx_q]) begin
            last_grant_q <= gidx_q;
            resp_valid_q <= '0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
`timescale 1ns/1ps
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int N_REQ   = 2;
  localparam int DATA_W  = 64;
  localparam int ALU_LAT = 2;

  logic                    CLK = 1'b0;
  logic                    Reset_L;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*4-1:0]      req_ctrl;
  logic [N_REQ-1:0]        resp_valid;
  logic [N_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]       resp_data;
  logic                    resp_zero;
  logic                    resp_err;
  logic [DATA_W-1:0]       alu_busa;
  logic [DATA_W-1:0]       alu_busb;
  logic [3:0]              alu_ctrl;
  logic [DATA_W-1:0]       alu_busw;
  logic                    alu_zero;

  typedef struct {
    int          idx;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctrl;
    logic [63:0] d;
    logic        z;
    logic        e;
  } vec_t;

  typedef struct {
    int          idx;
    logic [63:0] d;
    logic        z;
    logic        e;
    int          acc_cyc;
  } exp_t;

  vec_t op[N_REQ];
  vec_t tbl[9];
  exp_t sb[$];
  exp_t mon_x;
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   resp_cnt = 0;
  int   tb_last = N_REQ - 1;
  int   mon_g;
  bit   seen = 1'b0;

  always #7.5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  alu_share_ctrl #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ALU_LAT(ALU_LAT)) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .resp_err   (resp_err),
    .alu_busa   (alu_busa),
    .alu_busb   (alu_busb),
    .alu_ctrl   (alu_ctrl),
    .alu_busw   (alu_busw),
    .alu_zero   (alu_zero)
  );

  // Behavioural ALU attached to the shared ports.
  always_comb begin
    alu_busw = '0;
    case (alu_ctrl)
      ALU_AND: alu_busw = alu_busa & alu_busb;
      ALU_OR:  alu_busw = alu_busa | alu_busb;
      ALU_ADD: alu_busw = alu_busa + alu_busb;
      ALU_LSR: alu_busw = alu_busa >> alu_busb[5:0];
      ALU_LSL: alu_busw = alu_busa << alu_busb[5:0];
      ALU_SUB: alu_busw = alu_busa - alu_busb;
      ALU_SLT: alu_busw = {63'd0, ($signed(alu_busa) < $signed(alu_busb))};
      default: alu_busw = '0;
    endcase
    alu_zero = (alu_busw == '0);
  end

  always_comb begin
    req_a    = '0;
    req_b    = '0;
    req_ctrl = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = op[i].a;
      req_b[i*DATA_W +: DATA_W] = op[i].b;
      req_ctrl[i*4 +: 4]        = op[i].ctrl;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Accept monitor: predicts the round-robin winner and queues the expected response.
  // Response monitor: checks one-hot index, latency and payload on consumption.
  always @(negedge CLK) begin
    if (Reset_L) begin
      if (req_ready != '0) begin
        mon_g = -1;
        for (int off = 1; off <= N_REQ; off++)
          if (mon_g < 0 && req_valid[(tb_last + off) % N_REQ]) mon_g = (tb_last + off) % N_REQ;
        if (mon_g < 0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_without_valid: req_ready=%b req_valid=%b", req_ready, req_valid);
        end else begin
          chk("grant_onehot", 64'(req_ready), 64'(1) << mon_g);
          sb.push_back('{mon_g, op[mon_g].d, op[mon_g].z, op[mon_g].e, cyc + 1});
          grant_log.push_back(mon_g);
          tb_last = mon_g;
        end
        acc_cnt++;
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: resp_valid=%b with nothing outstanding", resp_valid);
        end else begin
          if (!seen) begin
            chk("resp_idx", 64'(resp_valid), 64'(1) << sb[0].idx);
            chk("resp_latency", 64'(cyc - sb[0].acc_cyc), sb[0].e ? 64'd0 : 64'(ALU_LAT));
            seen = 1'b1;
          end
          if ((resp_valid & resp_ready) != '0) begin
            mon_x = sb.pop_front();
            chk("resp_data", resp_data, mon_x.d);
            chk("resp_zero", 64'(resp_zero), 64'(mon_x.z));
            chk("resp_err", 64'(resp_err), 64'(mon_x.e));
            seen = 1'b0;
            resp_cnt++;
          end
        end
      end
    end
  end

  task automatic wait_acc(input int target, input string name);
    int n = 0;
    while (acc_cnt < target && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    n_cmp++;
    if (acc_cnt < target) begin
      n_bad++;
      $display("FAIL %s: accept timeout, accepts %0d, want %0d", name, acc_cnt, target);
    end
  endtask

  task automatic wait_resp(input int target, input string name);
    int n = 0;
    while (resp_cnt < target && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    n_cmp++;
    if (resp_cnt < target) begin
      n_bad++;
      $display("FAIL %s: response timeout, responses %0d, want %0d", name, resp_cnt, target);
    end
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int t = acc_cnt + 1;
    int r = resp_cnt + 1;
    op[v.idx] = v;
    req_valid[v.idx] = 1'b1;
    wait_acc(t, name);
    req_valid = '0;
    wait_resp(r, name);
    @(posedge CLK); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int r;
    int first;
    int base;

    tbl[0] = '{0, 64'd5, 64'd7, ALU_ADD, 64'd12, 1'b0, 1'b0};
    tbl[1] = '{1, 64'd1, 64'd63, ALU_LSL, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
    tbl[2] = '{0, 64'hF0, 64'd4, ALU_LSR, 64'hF, 1'b0, 1'b0};
    tbl[3] = '{1, 64'd3, 64'd5, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[4] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'd0, 1'b1, 1'b0};
    tbl[5] = '{1, 64'hF0F0, 64'h0FF0, ALU_AND, 64'h00F0, 1'b0, 1'b0};
    tbl[6] = '{0, 64'd9, 64'd9, 4'b0101, 64'd0, 1'b0, 1'b1};
    tbl[7] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_SLT, 64'd1, 1'b0, 1'b0};
    tbl[8] = '{0, 64'd0, 64'd0, ALU_OR, 64'd0, 1'b1, 1'b0};

    for (int i = 0; i < N_REQ; i++) op[i] = '{i, 64'd0, 64'd0, ALU_AND, 64'd0, 1'b1, 1'b0};

    // Reset state, with requests pending to show req_ready is held low.
    Reset_L    = 1'b0;
    req_valid  = '1;
    resp_ready = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_alu_busa", alu_busa, 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    req_valid = '0;
    Reset_L   = 1'b1;
    @(posedge CLK); #1;

    // Table-driven single-requester transactions.
    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Both requesters pending continuously: grants must alternate.
    op[0] = '{0, 64'd9, 64'd9, ALU_SUB, 64'd0, 1'b1, 1'b0};
    op[1] = '{1, 64'd1, 64'd2, ALU_OR, 64'd3, 1'b0, 1'b0};
    first = (tb_last + 1) % N_REQ;
    base  = grant_log.size();
    t = acc_cnt + 4;
    r = resp_cnt + 4;
    req_valid = '1;
    wait_acc(t, "alt_accepts");
    req_valid = '0;
    wait_resp(r, "alt_resps");
    for (int i = 0; i < 4; i++)
      chk($sformatf("alt_grant%0d", i), 64'(grant_log[base + i]), 64'((first + i) % N_REQ));
    @(posedge CLK); #1;

    // Undefined code must leave the ALU ports where the last legal job put them.
    run_txn('{0, 64'd100, 64'd23, ALU_ADD, 64'd123, 1'b0, 1'b0}, "pre_undef");
    run_txn('{1, 64'hAAAA, 64'h5555, 4'b1111, 64'd0, 1'b0, 1'b1}, "undef");
    chk("undef_alu_busa", alu_busa, 64'd100);
    chk("undef_alu_busb", alu_busb, 64'd23);
    chk("undef_alu_ctrl", 64'(alu_ctrl), 64'(ALU_ADD));

    // Response backpressure: hold resp_ready[0] low while req1 waits.
    op[0] = '{0, 64'd3, 64'd8, ALU_SLT, 64'd1, 1'b0, 1'b0};
    op[1] = '{1, 64'd4, 64'd4, ALU_ADD, 64'd8, 1'b0, 1'b0};
    resp_ready = 2'b10;
    t = acc_cnt + 1;
    r = resp_cnt + 2;
    req_valid = 2'b01;
    wait_acc(t, "hold_acc");
    req_valid = 2'b10;
    for (int n = 0; n < 10 && resp_valid == '0; n++) begin
      @(posedge CLK); #1;
    end
    for (int n = 0; n < 5; n++) begin
      @(posedge CLK); #1;
      chk($sformatf("hold_valid%0d", n), 64'(resp_valid), 64'd1);
      chk($sformatf("hold_data%0d", n), resp_data, 64'd1);
      chk($sformatf("hold_noready%0d", n), 64'(req_ready), 64'd0);
    end
    resp_ready = '1;
    wait_acc(t + 1, "hold_next_acc");
    req_valid = '0;
    wait_resp(r, "hold_resps");
    @(posedge CLK); #1;

    // Reset in the middle of EXEC: job dropped, pointer back to req0-first.
    op[0] = '{0, 64'd7, 64'd8, ALU_ADD, 64'd15, 1'b0, 1'b0};
    t = acc_cnt + 1;
    req_valid = 2'b01;
    wait_acc(t, "mid_acc");
    req_valid = '0;
    #3;
    Reset_L = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_alu_busa", alu_busa, 64'd0);
    chk("mid_rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("mid_rst_resp_err", 64'(resp_err), 64'd0);
    sb.delete();
    seen    = 1'b0;
    tb_last = N_REQ - 1;
    repeat (2) begin
      @(posedge CLK); #1;
      chk("mid_rst_no_resp", 64'(resp_valid), 64'd0);
    end
    Reset_L = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("post_rst_no_resp", 64'(resp_valid), 64'd0);
    end
    op[0] = '{0, 64'd2, 64'd3, ALU_ADD, 64'd5, 1'b0, 1'b0};
    op[1] = '{1, 64'd6, 64'd6, ALU_SUB, 64'd0, 1'b1, 1'b0};
    t = acc_cnt + 1;
    r = resp_cnt + 1;
    req_valid = 2'b11;
    wait_acc(t, "post_rst_acc");
    req_valid = '0;
    chk("post_rst_first_grant", 64'(grant_log[grant_log.size() - 1]), 64'd0);
    wait_resp(r, "post_rst_resp");
    repeat (3) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
